// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multi-cycle RV32M unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [3:0]      aluControl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, aluControl, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, aluControl, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: single-cycle multiply, radix-2 restoring divide.
//   state  | meaning
//   IDLE   | waiting for start, operands latched on launch
//   MUL    | product formed from latched operands
//   DIV    | one quotient bit per cycle on operand magnitudes
//   FIX    | sign correction and quotient/remainder select
//   DONE   | result valid, done pulse, back to IDLE
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] C_MUL    = 4'b1010;
    localparam logic [3:0] C_MULH   = 4'b1011;
    localparam logic [3:0] C_MULHSU = 4'b1100;
    localparam logic [3:0] C_MULHU  = 4'b1001;
    localparam logic [3:0] C_DIV    = 4'b1110;
    localparam logic [3:0] C_DIVU   = 4'b1111;
    localparam logic [3:0] C_REM    = 4'b0110;
    localparam logic [3:0] C_REMU   = 4'b0111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]      ctrl_q;
    logic [XLEN-1:0] a_q, b_q, rem_q, quot_q, div_q, result_q;
    logic            neg_quot_q, neg_rem_q, busy_q, done_q;

    logic            in_mul, in_div, in_signed, in_rem, in_special;
    logic [XLEN-1:0] special_res, a_abs, b_abs;
    logic            a_sext, b_sext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res, fix_res, rem_d, quot_d;
    logic [XLEN:0]   rem_sh, trial;

    always_comb begin
        in_mul      = bus.aluControl inside {C_MUL, C_MULH, C_MULHSU, C_MULHU};
        in_div      = bus.aluControl inside {C_DIV, C_DIVU, C_REM, C_REMU};
        in_signed   = ~bus.aluControl[0];
        in_rem      = ~bus.aluControl[3];
        special_res = '0;
        in_special  = 1'b1;
        if (in_mul) begin
            in_special = 1'b0;
        end else if (in_div) begin
            if (bus.op_b == '0)
                special_res = in_rem ? bus.op_a : '1;
            else if (in_signed && bus.op_a == MIN_NEG && bus.op_b == '1)
                special_res = in_rem ? '0 : MIN_NEG;
            else
                in_special = 1'b0;
        end
        a_abs = (in_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
        b_abs = (in_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    end

    // Sign-extending both operands to 2*XLEN makes one multiplier serve all four variants.
    always_comb begin
        a_sext  = (ctrl_q != C_MULHU) && a_q[XLEN-1];
        b_sext  = (ctrl_q == C_MUL || ctrl_q == C_MULH) && b_q[XLEN-1];
        prod    = {{XLEN{a_sext}}, a_q} * {{XLEN{b_sext}}, b_q};
        mul_res = (ctrl_q == C_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        rem_sh = {rem_q, quot_q[XLEN-1]};
        trial  = rem_sh - {1'b0, div_q};
        if (!trial[XLEN]) begin
            rem_d  = trial[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        fix_res = ctrl_q[3] ? (neg_quot_q ? -quot_q : quot_q)
                            : (neg_rem_q  ? -rem_q  : rem_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            div_q      <= '0;
            result_q   <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && bus.flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.flush) begin
                            ctrl_q <= bus.aluControl;
                            a_q    <= bus.op_a;
                            b_q    <= bus.op_b;
                            busy_q <= 1'b1;
                            if (in_special) begin
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                result_q <= special_res;
                            end else if (in_mul) begin
                                state_q <= S_MUL;
                            end else begin
                                state_q    <= S_DIV;
                                cnt_q      <= '0;
                                rem_q      <= '0;
                                quot_q     <= a_abs;
                                div_q      <= b_abs;
                                neg_quot_q <= in_signed && (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                                neg_rem_q  <= in_signed && bus.op_a[XLEN-1];
                            end
                        end
                    end
                    S_MUL: begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= mul_res;
                    end
                    S_DIV: begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(XLEN-1))
                            state_q <= S_FIX;
                    end
                    S_FIX: begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= fix_res;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A flush arriving while DONE is showing must still hide the completion from the pipeline.
    assign bus.done   = done_q & ~bus.flush;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;
endmodule
